// File: rtl/mic1_acc_serializer_if.sv
// Byte-stream handshake bundle for the accumulator serializer: input
// transfers, dump request and the byte-serial readout channel.
interface mic1_acc_serializer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_op;
  logic       dump_req;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output in_valid, in_data, in_op, dump_req, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_op, dump_req, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mic1_acc_serializer.sv
// DATA_W-bit accumulator fed by a byte stream, with a snapshot register that
// is streamed out byte-serially over valid/ready on request.
module mic1_acc_serializer #(
  parameter int DATA_W    = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  mic1_acc_serializer_if.slave bus,
  output logic              busy,
  output logic              overflow,
  output logic [DATA_W-1:0] acc_out
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_SHIFT = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_DUMP
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W:0]   sum, diff;
  logic [IDX_W-1:0]  byte_sel;
  logic              xfer, out_hs;

  assign xfer   = bus.in_valid && bus.in_ready;
  assign out_hs = bus.out_valid && bus.out_ready;

  // The extra top bit carries the carry (add) or borrow (sub) out of acc.
  assign sum  = {1'b0, acc_q} + {{(DATA_W - 7){1'b0}}, bus.in_data};
  assign diff = {1'b0, acc_q} - {{(DATA_W - 7){1'b0}}, bus.in_data};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (xfer) begin
      case (op_e'(bus.in_op))
        OP_ADD: begin
          acc_d = sum[DATA_W-1:0];
          ovf_d = ovf_q | sum[DATA_W];
        end
        OP_SUB: begin
          acc_d = diff[DATA_W-1:0];
          ovf_d = ovf_q | diff[DATA_W];
        end
        OP_SHIFT: acc_d = {acc_q[DATA_W-9:0], bus.in_data};
        OP_CLEAR: begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.dump_req) begin
          state_d = S_DUMP;
          snap_d  = acc_q;
          idx_d   = '0;
        end
      end
      S_DUMP: begin
        if (out_hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign byte_sel      = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
  assign bus.in_ready  = rst_n;
  assign bus.out_valid = (state_q == S_DUMP);
  assign bus.out_last  = (state_q == S_DUMP) && (idx_q == LAST_IDX);
  assign bus.out_data  = snap_q[{byte_sel, 3'b000} +: 8];
  assign busy          = (state_q == S_DUMP);
  assign overflow      = ovf_q;
  assign acc_out       = acc_q;

endmodule

// File: tb/tb_mic1_acc_serializer.sv
// Bench for mic1_acc_serializer: three instances (32-bit LSB-first, 32-bit
// MSB-first, 64-bit LSB-first) share stimulus; readout checked by scoreboard.
module tb_mic1_acc_serializer;

  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_SHF = 2'b10, OP_CLR = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mic1_acc_serializer_if bus_l ();
  mic1_acc_serializer_if bus_m ();
  mic1_acc_serializer_if bus_w ();

  logic        busy_l, busy_m, busy_w;
  logic        ovf_l, ovf_m, ovf_w;
  logic [31:0] acc_l, acc_m;
  logic [63:0] acc_w;

  mic1_acc_serializer #(.DATA_W(32), .MSB_FIRST(1'b0)) u32l (
    .clk(clk), .rst_n(rst_n), .bus(bus_l), .busy(busy_l), .overflow(ovf_l), .acc_out(acc_l));
  mic1_acc_serializer #(.DATA_W(32), .MSB_FIRST(1'b1)) u32m (
    .clk(clk), .rst_n(rst_n), .bus(bus_m), .busy(busy_m), .overflow(ovf_m), .acc_out(acc_m));
  mic1_acc_serializer #(.DATA_W(64), .MSB_FIRST(1'b0)) u64 (
    .clk(clk), .rst_n(rst_n), .bus(bus_w), .busy(busy_w), .overflow(ovf_w), .acc_out(acc_w));

  typedef struct {
    logic [7:0] d;
    bit         last;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  d;
    logic [31:0] acc;
    logic        ovf;
    bit          dump;
  } vec_t;

  exp_t q_l[$], q_m[$], q_w[$];
  exp_t e_l, e_m, e_w;
  vec_t tbl[16];

  int n_vec = 0;
  int n_err = 0;
  int hs_l = 0, hs_m = 0, hs_w = 0;

  // Reference model of the accumulator for each width.
  logic [31:0] m32;
  logic [63:0] m64;
  logic        o32, o64;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [7:0] d);
    bus_l.in_valid = v; bus_l.in_op = op; bus_l.in_data = d;
    bus_m.in_valid = v; bus_m.in_op = op; bus_m.in_data = d;
    bus_w.in_valid = v; bus_w.in_op = op; bus_w.in_data = d;
  endtask

  task automatic set_ctrl(input logic dreq, input logic rdy);
    bus_l.dump_req = dreq; bus_l.out_ready = rdy;
    bus_m.dump_req = dreq; bus_m.out_ready = rdy;
    bus_w.dump_req = dreq; bus_w.out_ready = rdy;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [7:0] d);
    logic [32:0] s32;
    logic [64:0] s64;
    case (op)
      OP_ADD: begin
        s32 = {1'b0, m32} + {25'd0, d};
        s64 = {1'b0, m64} + {57'd0, d};
        m32 = s32[31:0]; o32 = o32 | s32[32];
        m64 = s64[63:0]; o64 = o64 | s64[64];
      end
      OP_SUB: begin
        s32 = {1'b0, m32} - {25'd0, d};
        s64 = {1'b0, m64} - {57'd0, d};
        m32 = s32[31:0]; o32 = o32 | s32[32];
        m64 = s64[63:0]; o64 = o64 | s64[64];
      end
      OP_SHF: begin
        m32 = {m32[23:0], d};
        m64 = {m64[55:0], d};
      end
      default: begin
        m32 = '0; m64 = '0; o32 = 1'b0; o64 = 1'b0;
      end
    endcase
  endtask

  task automatic do_op(input logic [1:0] op, input logic [7:0] d);
    set_in(1'b1, op, d);
    model_op(op, d);
    step();
    set_in(1'b0, OP_ADD, 8'h00);
  endtask

  task automatic push_dump();
    for (int i = 0; i < 4; i++) begin
      q_l.push_back('{d: m32[8*i +: 8], last: (i == 3)});
      q_m.push_back('{d: m32[8*(3-i) +: 8], last: (i == 3)});
    end
    for (int i = 0; i < 8; i++) q_w.push_back('{d: m64[8*i +: 8], last: (i == 7)});
  endtask

  task automatic wait_idle(output int t_l, output int t_w);
    int k = 0;
    t_l = -1;
    t_w = -1;
    while ((busy_l || busy_w) && k < 20) begin
      step();
      k++;
      if (!busy_l && t_l < 0) t_l = k;
      if (!busy_w && t_w < 0) t_w = k;
    end
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_drain_l"}, 64'(q_l.size()), 64'd0);
    check({tag, "_drain_m"}, 64'(q_m.size()), 64'd0);
    check({tag, "_drain_w"}, 64'(q_w.size()), 64'd0);
  endtask

  task automatic run_dump(input string tag);
    int t_l, t_w;
    push_dump();
    set_ctrl(1'b1, 1'b1);
    step();
    set_ctrl(1'b0, 1'b1);
    check({tag, "_first_valid"}, 64'(bus_l.out_valid), 64'd1);
    wait_idle(t_l, t_w);
    check({tag, "_cycles_32"}, 64'(t_l), 64'd4);
    check({tag, "_cycles_64"}, 64'(t_w), 64'd8);
    check_drained(tag);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_l.out_valid && bus_l.out_ready) begin
      hs_l++;
      if (q_l.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_byte_l: got %h, expected no byte", bus_l.out_data);
      end else begin
        e_l = q_l.pop_front();
        check("byte_l", {bus_l.out_last, bus_l.out_data}, {e_l.last, e_l.d});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_m.out_valid && bus_m.out_ready) begin
      hs_m++;
      if (q_m.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_byte_m: got %h, expected no byte", bus_m.out_data);
      end else begin
        e_m = q_m.pop_front();
        check("byte_m", {bus_m.out_last, bus_m.out_data}, {e_m.last, e_m.d});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_w.out_valid && bus_w.out_ready) begin
      hs_w++;
      if (q_w.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_byte_w: got %h, expected no byte", bus_w.out_data);
      end else begin
        e_w = q_w.pop_front();
        check("byte_w", {bus_w.out_last, bus_w.out_data}, {e_w.last, e_w.d});
      end
    end
  end

  initial begin
    logic rdy_seq [6];
    int t_l, t_w;

    tbl[0]  = '{OP_CLR, 8'h00, 32'h0000_0000, 1'b0, 1'b0};
    tbl[1]  = '{OP_ADD, 8'h12, 32'h0000_0012, 1'b0, 1'b0};
    tbl[2]  = '{OP_ADD, 8'h34, 32'h0000_0046, 1'b0, 1'b1};
    tbl[3]  = '{OP_CLR, 8'h00, 32'h0000_0000, 1'b0, 1'b0};
    tbl[4]  = '{OP_SHF, 8'hDE, 32'h0000_00DE, 1'b0, 1'b0};
    tbl[5]  = '{OP_SHF, 8'hAD, 32'h0000_DEAD, 1'b0, 1'b0};
    tbl[6]  = '{OP_SHF, 8'hBE, 32'h00DE_ADBE, 1'b0, 1'b0};
    tbl[7]  = '{OP_SHF, 8'hEF, 32'hDEAD_BEEF, 1'b0, 1'b1};
    tbl[8]  = '{OP_CLR, 8'h00, 32'h0000_0000, 1'b0, 1'b0};
    tbl[9]  = '{OP_SUB, 8'h01, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[10] = '{OP_ADD, 8'h01, 32'h0000_0000, 1'b1, 1'b0};
    tbl[11] = '{OP_CLR, 8'h00, 32'h0000_0000, 1'b0, 1'b0};
    tbl[12] = '{OP_SHF, 8'h11, 32'h0000_0011, 1'b0, 1'b0};
    tbl[13] = '{OP_SHF, 8'h22, 32'h0000_1122, 1'b0, 1'b0};
    tbl[14] = '{OP_SHF, 8'h33, 32'h0011_2233, 1'b0, 1'b0};
    tbl[15] = '{OP_SHF, 8'h44, 32'h1122_3344, 1'b0, 1'b0};

    m32 = '0; m64 = '0; o32 = 1'b0; o64 = 1'b0;
    rst_n = 1'b0;
    set_in(1'b0, OP_ADD, 8'h00);
    set_ctrl(1'b0, 1'b1);
    repeat (2) step();
    check("rst_acc_l", 64'(acc_l), 64'd0);
    check("rst_acc_w", acc_w, 64'd0);
    check("rst_ovf", 64'(ovf_l), 64'd0);
    check("rst_valid", 64'(bus_l.out_valid), 64'd0);
    check("rst_last", 64'(bus_l.out_last), 64'd0);
    check("rst_busy", 64'(busy_l), 64'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready", 64'(bus_l.in_ready), 64'd1);
    step();

    // Accumulate table; some entries follow up with a full dump.
    for (int i = 0; i < 16; i++) begin
      do_op(tbl[i].op, tbl[i].d);
      check($sformatf("vec%0d_acc_l", i), 64'(acc_l), 64'(tbl[i].acc));
      check($sformatf("vec%0d_acc_m", i), 64'(acc_m), 64'(tbl[i].acc));
      check($sformatf("vec%0d_ovf_l", i), 64'(ovf_l), 64'(tbl[i].ovf));
      check($sformatf("vec%0d_acc_w", i), acc_w, m64);
      check($sformatf("vec%0d_ovf_w", i), 64'(ovf_w), 64'(o64));
      if (tbl[i].dump) run_dump($sformatf("dump%0d", i));
    end

    // Snapshot taken before a same-edge add; later adds leave the stream alone.
    push_dump();
    set_ctrl(1'b1, 1'b1);
    set_in(1'b1, OP_ADD, 8'h01);
    model_op(OP_ADD, 8'h01);
    step();
    set_ctrl(1'b0, 1'b1);
    check("same_edge_acc_l", 64'(acc_l), 64'h1122_3345);
    check("same_edge_byte0", 64'(bus_l.out_data), 64'h44);
    set_in(1'b1, OP_ADD, 8'h05);
    model_op(OP_ADD, 8'h05);
    step();
    set_in(1'b0, OP_ADD, 8'h00);
    wait_idle(t_l, t_w);
    check("during_dump_acc_l", 64'(acc_l), 64'h1122_334A);
    check("during_dump_acc_w", acc_w, m64);
    check_drained("same_edge");

    // Backpressure stall with ignored dump requests mid-dump and on the last byte.
    do_op(OP_CLR, 8'h00);
    do_op(OP_SHF, 8'hA1);
    do_op(OP_SHF, 8'hB2);
    do_op(OP_SHF, 8'hC3);
    do_op(OP_SHF, 8'hD4);
    hs_l = 0; hs_m = 0; hs_w = 0;
    rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    push_dump();
    set_ctrl(1'b1, 1'b1);
    step();
    for (int i = 0; i < 6; i++) begin
      set_ctrl((i == 1) || (i == 5), rdy_seq[i]);
      if (!rdy_seq[i]) begin
        #1;
        check($sformatf("stall%0d_data", i), 64'(bus_l.out_data), 64'hC3);
        check($sformatf("stall%0d_last", i), 64'(bus_l.out_last), 64'd0);
      end
      step();
    end
    set_ctrl(1'b0, 1'b1);
    check("stall_hs_l", 64'(hs_l), 64'd4);
    check("stall_busy_l", 64'(busy_l), 64'd0);
    step();
    check("stall_no_restart", 64'(bus_l.out_valid), 64'd0);
    wait_idle(t_l, t_w);
    check("stall_hs_m", 64'(hs_m), 64'd4);
    check("stall_hs_w", 64'(hs_w), 64'd8);
    check_drained("stall");

    // Reset while the second byte is on the bus abandons the dump.
    push_dump();
    set_ctrl(1'b1, 1'b1);
    step();
    set_ctrl(1'b0, 1'b1);
    step();
    check("pre_rst_byte2", 64'(bus_l.out_data), 64'hC3);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid_l", 64'(bus_l.out_valid), 64'd0);
    check("mid_rst_valid_w", 64'(bus_w.out_valid), 64'd0);
    check("mid_rst_acc_l", 64'(acc_l), 64'd0);
    check("mid_rst_acc_w", acc_w, 64'd0);
    rst_n = 1'b1;
    q_l.delete(); q_m.delete(); q_w.delete();
    m32 = '0; m64 = '0; o32 = 1'b0; o64 = 1'b0;
    hs_l = 0; hs_m = 0; hs_w = 0;
    step();
    run_dump("zero_dump");
    check("zero_hs_l", 64'(hs_l), 64'd4);
    check("zero_hs_w", 64'(hs_w), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
